// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Brief   : Shared UART types and constants (state enum, data width, divider).
// Rev     : 1.0
// ============================================================================
package uart_pkg;

  localparam int unsigned UART_DATA_W      = 8;
  localparam int unsigned UART_DEF_CLK_DIV = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module  : uart_baud_cnt
// Brief   : Bit-period divider, counts 0..CLK_DIV-1 and flags the last cycle.
// Rev     : 1.0
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_DEF_CLK_DIV
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr_i,
  output logic bit_done_o
);

  localparam int unsigned            c_cnt_w = $clog2(CLK_DIV);
  localparam logic [c_cnt_w-1:0]     c_last  = c_cnt_w'(CLK_DIV - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  assign bit_done_o = (cnt_q == c_last);

  always_comb begin
    cnt_d = cnt_q + c_cnt_w'(1);
    if (clr_i || bit_done_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_serializer
// Brief   : UART TX serializer with one-byte holding register and overrun flag.
//           Define UART_TX_PARITY_EN to insert a parity bit after D7.
// Rev     : 1.0
// ============================================================================
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = UART_DEF_CLK_DIV,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_data_valid,
  output logic                   tx_data_ack,
  output logic                   txd,
  output logic                   tx_busy,
  output logic                   tx_hold_full,
  output logic                   tx_overrun,
  input  logic                   tx_overrun_clr
);

  localparam logic [2:0] c_last_stop = 3'(STOP_BITS - 1);

  uart_state_e            state_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic [UART_DATA_W-1:0] hold_q;
  logic                   hold_vld_q;
  logic [2:0]             bit_cnt_q;
  logic                   txd_q;
  logic                   ack_q;
  logic                   overrun_q;

  logic                   w_bit_done;
  logic                   w_frame_end;
  logic                   w_direct_load;
  logic                   w_load;
  logic [UART_DATA_W-1:0] w_load_byte;

  uart_baud_cnt #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .clr_i      (state_q == IDLE),
    .bit_done_o (w_bit_done)
  );

  assign w_frame_end   = (state_q == STOP) && w_bit_done && (bit_cnt_q == c_last_stop);
  // A write landing on the frame-end cycle with an empty hold goes straight to the shifter.
  assign w_direct_load = tx_data_valid && ((state_q == IDLE) || (w_frame_end && !hold_vld_q));
  assign w_load        = w_direct_load || (w_frame_end && hold_vld_q);
  assign w_load_byte   = hold_vld_q ? hold_q : tx_data;

`ifdef UART_TX_PARITY_EN
  logic par_q;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = (PARITY_ODD != 0);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      bit_cnt_q  <= '0;
      txd_q      <= 1'b1;
      ack_q      <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;

      case (state_q)
        IDLE: ;
        START: begin
          if (w_bit_done) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            txd_q     <= shift_q[0];
          end
        end
        DATA: begin
          if (w_bit_done) begin
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              txd_q     <= par_q;
`else
              state_q   <= STOP;
              txd_q     <= 1'b1;
              bit_cnt_q <= '0;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_done) begin
            state_q   <= STOP;
            txd_q     <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
`endif
        STOP: begin
          if (w_bit_done) begin
            if (bit_cnt_q == c_last_stop) begin
              ack_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase

      if (w_load) begin
        shift_q    <= w_load_byte;
        state_q    <= START;
        txd_q      <= 1'b0;
        bit_cnt_q  <= '0;
        hold_vld_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q      <= uart_parity(w_load_byte, PARITY_ODD != 0);
`endif
      end

      // Clear first so a simultaneous drop keeps the flag set.
      if (tx_overrun_clr) begin
        overrun_q <= 1'b0;
      end
      if (tx_data_valid && !w_direct_load) begin
        if (!hold_vld_q || w_frame_end) begin
          hold_q     <= tx_data;
          hold_vld_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign txd          = txd_q;
  assign tx_data_ack  = ack_q;
  assign tx_busy      = (state_q != IDLE) || hold_vld_q;
  assign tx_hold_full = hold_vld_q;
  assign tx_overrun   = overrun_q;

endmodule
`default_nettype wire
